// File: rtl/tile_pkg.sv
// Shared constants, FSM states and tile types for the board shuffle
// sequencer and its helpers.
package tile_pkg;

  localparam int NUM_EDGE     = 24;
  localparam int NUM_CENTER   = 12;
  localparam int TILE_W       = 4;
  localparam int NUM_PICTURES = 12;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EDGE,
    CENTER,
    DONE
  } state_e;

  typedef logic [TILE_W-1:0] tile_code_t;

  // Scaled draw: the 13-bit product keeps j within 0..idx.
  function automatic logic [4:0] draw_idx(
    input logic [15:0] rnd,
    input logic [4:0]  idx
  );
    logic [12:0] prod;
    prod = {5'd0, rnd[7:0]} * {8'd0, idx + 5'd1};
    return prod[12:8];
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR with synchronous reset to SEED
// and an optional parallel load that overrides the advance.
module lfsr_galois #(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = 'hACE1,
  parameter logic [W-1:0] MASK = 'hB400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[W-1:1]};
    if (q_q[0]) q_d = q_d ^ MASK;
    if (load) q_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tile_shuffle_ctrl.sv
// Board layout generator: Fisher-Yates shuffle of edge/center tiles.
// Optional SHUFFLE_SEED_LOAD_EN adds seed_load/seed_in LFSR reseeding.
module tile_shuffle_ctrl
  import tile_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SHUFFLE_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
`endif
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        order_valid,
  output logic [95:0] random_edge_order,
  output logic [47:0] random_center_order
);

  if (SEED == '0) begin : g_bad_seed
    $error("tile_shuffle_ctrl: SEED must be nonzero");
  end
  if (LFSR_W != 16) begin : g_bad_width
    $error("tile_shuffle_ctrl: only LFSR_W=16 is supported");
  end

  state_e state_q, state_d;

  logic [4:0]  i_q, i_d;
  logic [4:0]  j;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [95:0] edge_out_q, edge_out_d;
  logic [47:0] center_out_q, center_out_d;

  tile_code_t edge_q   [NUM_EDGE];
  tile_code_t edge_d   [NUM_EDGE];
  tile_code_t center_q [NUM_CENTER];
  tile_code_t center_d [NUM_CENTER];

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_val;

`ifdef SHUFFLE_SEED_LOAD_EN
  assign lfsr_load = seed_load;
  assign lfsr_val  = (seed_in == '0) ? SEED : seed_in;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_val  = SEED;
`endif

  lfsr_galois #(
    .W    (LFSR_W),
    .SEED (SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_val),
    .q        (lfsr_q)
  );

  assign j = draw_idx(lfsr_q, i_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD:   state_d = EDGE;
      EDGE:   if (i_q == 5'd1) state_d = CENTER;
      CENTER: if (i_q == 5'd1) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy                = (state_q != IDLE);
    done                = done_q;
    order_valid         = valid_q;
    random_edge_order   = edge_out_q;
    random_center_order = center_out_q;
  end

  always_comb begin
    edge_d       = edge_q;
    center_d     = center_q;
    i_d          = i_q;
    edge_out_d   = edge_out_q;
    center_out_d = center_out_q;
    done_d       = 1'b0;
    valid_d      = valid_q;
    unique case (state_q)
      LOAD: begin
        for (int k = 0; k < NUM_EDGE; k++)
          edge_d[k] = tile_code_t'(k >> 1);
        for (int k = 0; k < NUM_CENTER; k++)
          center_d[k] = tile_code_t'(k);
        i_d = 5'(NUM_EDGE - 1);
      end
      EDGE: begin
        edge_d[i_q] = edge_q[j];
        edge_d[j]   = edge_q[i_q];
        if (i_q == 5'd1) i_d = 5'(NUM_CENTER - 1);
        else             i_d = i_q - 5'd1;
      end
      CENTER: begin
        center_d[i_q[3:0]] = center_q[j[3:0]];
        center_d[j[3:0]]   = center_q[i_q[3:0]];
        i_d = i_q - 5'd1;
      end
      // Outputs only change here, so they never show a partial shuffle.
      DONE: begin
        for (int k = 0; k < NUM_EDGE; k++)
          edge_out_d[k*TILE_W +: TILE_W] = edge_q[k];
        for (int k = 0; k < NUM_CENTER; k++)
          center_out_d[k*TILE_W +: TILE_W] = center_q[k];
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q          <= '0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      edge_out_q   <= '0;
      center_out_q <= '0;
      for (int k = 0; k < NUM_EDGE; k++)
        edge_q[k] <= '0;
      for (int k = 0; k < NUM_CENTER; k++)
        center_q[k] <= '0;
    end else begin
      i_q          <= i_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      edge_out_q   <= edge_out_d;
      center_out_q <= center_out_d;
      edge_q       <= edge_d;
      center_q     <= center_d;
    end
  end

endmodule

// File: doc/tile_shuffle_ctrl.md
Name: tile_shuffle_ctrl

Overview:
Sequencer that generates a fresh random board layout on request. It uses a free-running Galois LFSR and an in-place Fisher-Yates shuffle over a working register array. The outputs are the 24 edge-tile and 12 center-tile picture orders consumed by board rendering and game logic. A start/busy/done handshake lets the game FSM request a new layout at game start.

Parameters:
- LFSR_W, 16, LFSR width in bits. Polynomial is fixed for 16: x^16+x^14+x^13+x^11+1, Galois mask 16'hB400.
- SEED, 16'hACE1, LFSR reset value. Must be nonzero; a zero value is a configuration error flagged by an elaboration-time check.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request a new shuffle. Sampled only in IDLE.
- busy, output, 1, high from LOAD through DONE.
- done, output, 1, single-cycle pulse when new orders are valid.
- order_valid, output, 1, sticky. Set by the first done; cleared only by rst.
- random_edge_order, output, 96, 24 x 4-bit picture codes. Position k is at bits [4k+3:4k].
- random_center_order, output, 48, 12 x 4-bit picture codes. Same packing.

Behaviour:
- Reset (sync, active-high): state=IDLE, LFSR=SEED, all outputs 0, working arrays 0.
- The LFSR advances every clock in every state, including IDLE, so that request timing adds entropy.
- Draw rule: r = LFSR[7:0]. For current index i, j = (r*(i+1))>>8 using a 13-bit product, which guarantees 0<=j<=i.
- IDLE: if start=1, go to LOAD. Otherwise stay.
- LOAD (1 cycle): edge[k]=k>>1 for k=0..23, giving each code 0..11 twice. center[k]=k for k=0..11. Set i=23.
- EDGE (23 cycles, i=23 down to 1): swap edge[i] and edge[j] in one cycle. After i=1, set i=11 and go to CENTER.
- CENTER (11 cycles, i=11 down to 1): swap center[i] and center[j]. After i=1, go to DONE.
- DONE (1 cycle): on the exiting edge, the output registers capture the working arrays, done is set for the next cycle, order_valid is set, and state returns to IDLE.
- Latency: start sampled at edge T gives busy=1 in cycles T+1..T+36, and done=1 with the new outputs in cycle T+37. In that same cycle busy=0 and a new start is accepted.
- start while busy is ignored, with no queueing. start held high gives back-to-back shuffles, one done every 37 cycles.
- Outputs hold the previous layout throughout a shuffle and never show partial results.
- Output contents are always a valid multiset: edge has each code 0..11 exactly twice, center has each code exactly once. Codes 12..15 never appear.
- rst mid-shuffle: immediate return to IDLE, no done, outputs and order_valid cleared to 0.

Optional Feature:
- Macro SHUFFLE_SEED_LOAD_EN.
- With the macro defined: adds input seed_load (1) and input seed_in (16).
  - seed_load=1 loads the LFSR with seed_in, or with SEED if seed_in==0, taking priority over the normal advance. This works in any state.
  - Intended use: reproducible layouts for debug and replay.
- Without the macro: the ports are absent and the LFSR is touched only by rst and its free-running advance.

Decomposition:
- Package tile_pkg:
  - Constants NUM_EDGE=24, NUM_CENTER=12, TILE_W=4, NUM_PICTURES=12, LFSR_MASK=16'hB400.
  - State enum {IDLE, LOAD, EDGE, CENTER, DONE}.
  - tile_code_t (4-bit) typedef.
- Sub-module lfsr_galois:
  - Ports: clk, rst, load, load_val, q.
  - Instantiated once.
  - The shuffle FSM, index counter and swap logic stay in tile_shuffle_ctrl.

Test Plan:
1. Reset, wait 5 cycles, pulse start -> done rises exactly 37 cycles after the start edge. busy is high for 36 cycles. Edge output has each code 0..11 exactly twice, center output each code exactly once.
2. Two runs from reset with start asserted on cycle 10 -> bit-identical random_edge_order and random_center_order. Start on cycle 11 instead -> edge output differs.
3. Pulse start again at cycles T+5 and T+20 while busy -> no extra done, exactly one done at T+37. Outputs are unchanged from the prior layout until then.
4. Assert rst at cycle T+15 mid-shuffle -> no done, outputs read 0, order_valid=0, busy=0 on the next cycle. A fresh start completes normally.
5. Hold start high for 200 cycles -> done at T+37, T+74, T+111, T+148, T+185. The multiset property holds at every done.
6. With SHUFFLE_SEED_LOAD_EN, seed_load with seed_in=16'h1234 followed by start on the next cycle, repeated twice -> identical orders both times. seed_in=0 behaves identically to loading SEED.
